// File: rtl/lc3_mem_arbiter_pkg.sv
// Shared types and defaults for the LC3 memory arbiter and its RAM.
package lc3_mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CORE = 2'b01,
    OWN_LDR  = 2'b10
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CORE   = 2'd1,
    ST_LOADER = 2'd2,
    ST_LOCKED = 2'd3
  } arb_state_t;

  // A locked burst still belongs to the loader as far as the owner port is concerned.
  function automatic owner_t state_owner(input arb_state_t s);
    case (s)
      ST_CORE:              return OWN_CORE;
      ST_LOADER, ST_LOCKED: return OWN_LDR;
      default:              return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lc3_mem_arbiter_array.sv
// Single-port RAM with synchronous read; contents are deliberately not reset.
module lc3_mem_array
  import lc3_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Per-cycle arbiter sharing one program/data RAM between the LC3 core and the loader port.
// Grants are combinational; the core wrapper stalls on c_req && !c_gnt.
module lc3_mem_arbiter
  import lc3_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CORE_PRIO = 1,
  parameter int MAX_WAIT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic [1:0]        owner,
  output logic [3:0]        wait_cnt
);

  // state     | meaning
  // ST_IDLE   | no grant since reset
  // ST_CORE   | core won the last granted cycle
  // ST_LOADER | loader won the last granted cycle, no burst lock
  // ST_LOCKED | loader holds the memory for a locked burst

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);
  localparam logic [3:0] WAIT_SAT   = 4'hF;

  arb_state_t        state, state_nxt;
  owner_t            owner_q;
  logic [3:0]        wait_q, wait_nxt;
  logic              lock_hold;
  logic              ldr_turn;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [DATA_W-1:0] c_hold, l_hold;

  // Grants are held off while reset is low so no memory access slips through.
  always_comb begin
    c_gnt     = 1'b0;
    l_gnt     = 1'b0;
    ldr_turn  = 1'b0;
    state_nxt = state;
    lock_hold = (state == ST_LOCKED) && l_req && l_lock;
    if (reset) begin
      if (lock_hold) begin
        l_gnt = 1'b1;
      end else if (c_req && l_req) begin
        if (CORE_PRIO != 0) ldr_turn = (wait_q == WAIT_LIMIT);
        else                ldr_turn = (state == ST_CORE);
        l_gnt = ldr_turn;
        c_gnt = !ldr_turn;
      end else begin
        c_gnt = c_req;
        l_gnt = l_req;
      end

      if (l_gnt)                   state_nxt = l_lock ? ST_LOCKED : ST_LOADER;
      else if (c_gnt)              state_nxt = ST_CORE;
      else if (state == ST_LOCKED) state_nxt = ST_LOADER;
    end
  end

  // Starvation counter only matters when the core has fixed priority.
  always_comb begin
    wait_nxt = 4'd0;
    if ((CORE_PRIO != 0) && l_req && !l_gnt)
      wait_nxt = (wait_q == WAIT_SAT) ? WAIT_SAT : wait_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      owner_q  <= OWN_NONE;
      wait_q   <= 4'd0;
      c_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
      c_hold   <= '0;
      l_hold   <= '0;
    end else begin
      state    <= state_nxt;
      owner_q  <= state_owner(state_nxt);
      wait_q   <= wait_nxt;
      c_rvalid <= c_gnt && !c_we;
      l_rvalid <= l_gnt && !l_we;
      if (c_rvalid) c_hold <= mem_rdata;
      if (l_rvalid) l_hold <= mem_rdata;
    end
  end

  assign mem_we    = (c_gnt && c_we) || (l_gnt && l_we);
  assign mem_re    = (c_gnt && !c_we) || (l_gnt && !l_we);
  assign mem_addr  = l_gnt ? l_addr : c_addr;
  assign mem_wdata = l_gnt ? l_wdata : c_wdata;

  lc3_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // The RAM output register is shared, so each port keeps its own copy once rvalid drops.
  assign c_rdata  = c_rvalid ? mem_rdata : c_hold;
  assign l_rdata  = l_rvalid ? mem_rdata : l_hold;
  assign owner    = owner_q;
  assign wait_cnt = wait_q;

endmodule
